// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding and pass limit for the multi-pass shift sequencer
package shift_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AMT_W_DEF  = 8;

    localparam logic [4:0] MAX_STEP = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - single-pass barrel shifter, 0..31 positions, left / logical right / arithmetic right
module shifter #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] in,
    input  logic [4:0]        shamt,
    input  logic              left,
    input  logic              logical,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = in;
        if (left) begin
            out = in << shamt;
        end else if (logical) begin
            out = in >> shamt;
        end else begin
            out = DATA_W'($signed(in) >>> shamt);
        end
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-pass shift sequencer; optional SHIFT_SEQ_EARLY_EXIT_EN stops at a fixed-point result
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AMT_W  = AMT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    input  logic              left,
    input  logic              logical,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    state_t             state;
    state_t             next_state;
    logic [DATA_W-1:0]  acc;
    logic [AMT_W-1:0]   rem;
    logic               left_q;
    logic               logical_q;
    logic [4:0]         step;
    logic [AMT_W-1:0]   rem_next;
    logic [DATA_W-1:0]  sh_out;
    logic               fixed_pt;

    always_comb begin
        step     = (rem > AMT_W'(MAX_STEP)) ? MAX_STEP : rem[4:0];
        rem_next = rem - AMT_W'(step);
    end

    shifter #(.DATA_W(DATA_W)) u_shifter (
        .in      (acc),
        .shamt   (step),
        .left    (left_q),
        .logical (logical_q),
        .out     (sh_out)
    );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Further passes cannot change a result of all zeros, or all sign bits on an arithmetic right shift.
    always_comb begin
        fixed_pt = (sh_out == '0) || (!left_q && !logical_q && (sh_out == '1));
    end
`else
    always_comb begin
        fixed_pt = 1'b0;
    end
`endif

    always_comb begin
        next_state  = state;
        start_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                // A zero amount still spends one zero-step pass so every request costs at least one cycle.
                if (start_valid) next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rem_next == '0 || fixed_pt) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            rem       <= '0;
            left_q    <= 1'b0;
            logical_q <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            res_valid <= (next_state == ST_DONE);
            busy      <= (next_state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        acc       <= data_in;
                        rem       <= amt;
                        left_q    <= left;
                        logical_q <= logical;
                    end
                end
                ST_SHIFT: begin
                    acc <= sh_out;
                    rem <= rem_next;
                    if (next_state == ST_DONE) res_data <= sh_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed self-checking bench for shift_seq
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] data_in;
    logic [7:0]  amt;
    logic        left;
    logic        logical;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int checks = 0;
    int passed = 0;

    shift_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .data_in     (data_in),
        .amt         (amt),
        .left        (left),
        .logical     (logical),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic accept(input logic [31:0] d, input logic [7:0] a, input logic l, input logic lg);
        start_valid = 1'b1;
        data_in     = d;
        amt         = a;
        left        = l;
        logical     = lg;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        data_in = '0;
        amt = '0;
        left = 1'b0;
        logical = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b100)
            $display("FAIL reset_ctrl: got rdy/val/busy=%b want 100", {start_ready, res_valid, busy});
        else passed++;
        checks++;
        if (res_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", res_data);
        else passed++;
    endtask

    task automatic test_shift();
        logic [31:0] vd   [8] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h00000001,
                                  32'h00000001, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic [7:0]  va   [8] = '{8'd3, 8'd3, 8'd3, 8'd31, 8'd40, 8'd255, 8'd40, 8'd33};
        logic        vl   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        vlg  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] vexp [8] = '{32'hF0000000, 32'h10000000, 32'h00000000, 32'h80000000,
                                  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int          vlat [8] = '{1, 1, 1, 1, 2, 1, 1, 1};
`else
        int          vlat [8] = '{1, 1, 1, 1, 2, 9, 2, 2};
`endif
        int lat;
        for (int i = 0; i < 8; i++) begin
            accept(vd[i], va[i], vl[i], vlg[i]);
            wait_valid(lat);
            checks++;
            if (lat !== vlat[i]) $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, vlat[i]);
            else passed++;
            checks++;
            if (res_data !== vexp[i]) $display("FAIL shift%0d_data: got %h want %h", i, res_data, vexp[i]);
            else passed++;
            handoff();
            checks++;
            if ({res_valid, start_ready, busy} !== 3'b010)
                $display("FAIL shift%0d_after_handoff: got val/rdy/busy=%b want 010", i,
                         {res_valid, start_ready, busy});
            else passed++;
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad = 0;
        accept(32'h12345678, 8'd0, 1'b0, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== 1 || res_data !== 32'h12345678)
            $display("FAIL hold_first: got lat=%0d data=%h want lat=1 data=12345678", lat, res_data);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({res_valid, start_ready, busy} !== 3'b101 || res_data !== 32'h12345678) begin
                $display("FAIL hold_cycle%0d: got val/rdy/busy=%b data=%h want 101 12345678", c,
                         {res_valid, start_ready, busy}, res_data);
                bad++;
            end else passed++;
        end
        handoff();
        checks++;
        if (res_valid !== 1'b0) $display("FAIL hold_release: got res_valid=%b want 0", res_valid);
        else passed++;
    endtask

    task automatic test_reset_midshift();
        int lat;
        int seen = 0;
        accept(32'hF0F0F0F0, 8'd200, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0)
            $display("FAIL rstmid_busy: got busy=%b rdy=%b want 1 0", busy, start_ready);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({start_ready, busy, res_valid} !== 3'b100 || res_data !== 32'h0)
            $display("FAIL rstmid_state: got rdy/busy/val=%b data=%h want 100 00000000",
                     {start_ready, busy, res_valid}, res_data);
        else passed++;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL rstmid_no_result: got %0d valid cycles want 0", seen);
        else passed++;
        accept(32'h0000FFFF, 8'd4, 1'b1, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 1 || res_data !== 32'h000FFFF0)
            $display("FAIL rstmid_next: got lat=%0d data=%h want lat=1 data=000ffff0", lat, res_data);
        else passed++;
        handoff();
    endtask

    task automatic test_back_to_back();
        int lat;
        accept(32'h00000010, 8'd2, 1'b0, 1'b1);
        start_valid = 1'b1;
        data_in = 32'hFFFF0000;
        amt = 8'd8;
        left = 1'b1;
        logical = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== 1 || res_data !== 32'h00000004)
            $display("FAIL b2b_first: got lat=%0d data=%h want lat=1 data=00000004", lat, res_data);
        else passed++;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        checks++;
        if ({start_ready, busy, res_valid} !== 3'b100)
            $display("FAIL b2b_not_same_cycle: got rdy/busy/val=%b want 100", {start_ready, busy, res_valid});
        else passed++;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        checks++;
        if ({start_ready, busy} !== 2'b01)
            $display("FAIL b2b_accept_next: got rdy/busy=%b want 01", {start_ready, busy});
        else passed++;
        wait_valid(lat);
        checks++;
        if (lat !== 1 || res_data !== 32'hFF000000)
            $display("FAIL b2b_second: got lat=%0d data=%h want lat=1 data=ff000000", lat, res_data);
        else passed++;
        handoff();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_hold();
        test_reset_midshift();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
